// File: rtl/direction_control_multi_if.sv
// Sensor inputs, travel sense and motor/state outputs of direction_control_multi.
// The bench drives through master; the controller attaches as slave.
interface direction_control_multi_if #(
    parameter int N_SENSORS = 3
);
    logic [N_SENSORS-1:0] rs;
    logic [N_SENSORS-1:0] ls;
    logic                 direction;
    logic [3:0]           DIR;
    logic [2:0]           state;
    logic                 blocked;

    modport master (
        output rs, ls, direction,
        input  DIR, state, blocked
    );

    modport slave (
        input  rs, ls, direction,
        output DIR, state, blocked
    );
endinterface

// File: rtl/direction_control_multi.sv
// Obstacle-avoidance wheel controller: sync + debounce per sensor, steering FSM, registered DIR.
// Raw-to-DIR latency DEBOUNCE_CYCLES+3 edges; no backpressure. DIRCTL_BACKOFF_EN adds BACKOFF/SPIN recovery.
module direction_control_multi #(
    parameter int N_SENSORS       = 3,
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int BACKOFF_CYCLES  = 250000,
    parameter int SPIN_CYCLES     = 250000
) (
    input logic                      clk,
    input logic                      rst,
    direction_control_multi_if.slave bus
);
    localparam int NB  = 2 * N_SENSORS;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        CRUISE  = 3'd0,
        TURN_L  = 3'd1,
        TURN_R  = 3'd2,
        BLOCKED = 3'd3,
        BACKOFF = 3'd4,
        SPIN    = 3'd5,
        STOP    = 3'd6
    } state_t;

    // Upper half carries the left sensors, lower half the right sensors.
    logic [NB-1:0]  raw;
    logic [NB-1:0]  sync1;
    logic [NB-1:0]  sync2;
    logic [NB-1:0]  filt;
    logic [DBW-1:0] db_cnt [NB];
    logic           l_obs;
    logic           r_obs;

    state_t cur;
    state_t nxt;

    assign raw = {bus.ls, bus.rs};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A bit only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign l_obs = |filt[NB-1:N_SENSORS];
    assign r_obs = |filt[N_SENSORS-1:0];

`ifdef DIRCTL_BACKOFF_EN
    localparam int PHASE_MAX = (BACKOFF_CYCLES > SPIN_CYCLES) ? BACKOFF_CYCLES : SPIN_CYCLES;
    localparam int PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam logic [PW-1:0] PHASE_SAT    = PW'(PHASE_MAX - 1);
    localparam logic [PW-1:0] BACKOFF_LAST = PW'(BACKOFF_CYCLES - 1);
    localparam logic [PW-1:0] SPIN_LAST    = PW'(SPIN_CYCLES - 1);

    logic [PW-1:0] phase;

    // Cleared on every state change, saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (nxt != cur) begin
            phase <= '0;
        end else if (phase != PHASE_SAT) begin
            phase <= phase + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{BACKOFF_CYCLES, SPIN_CYCLES};
`endif

    function automatic state_t steer(input logic l, input logic r);
        state_t s;
        case ({l, r})
            2'b00:   s = CRUISE;
            2'b10:   s = TURN_R;
            2'b01:   s = TURN_L;
            default: s = BLOCKED;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] dir_code(input state_t s, input logic rev);
        logic [3:0] d;
        d = 4'b0000;
        case (s)
            CRUISE:  d = rev ? 4'b0101 : 4'b1010;
            TURN_R:  d = rev ? 4'b0100 : 4'b1000;
            TURN_L:  d = rev ? 4'b0001 : 4'b0010;
`ifdef DIRCTL_BACKOFF_EN
            BACKOFF: d = rev ? 4'b1010 : 4'b0101;
            SPIN:    d = rev ? 4'b0110 : 4'b1001;
`endif
            default: d = 4'b0000;
        endcase
        return d;
    endfunction

    always_comb begin
        nxt = cur;
        case (cur)
            CRUISE, TURN_L, TURN_R: nxt = steer(l_obs, r_obs);
`ifdef DIRCTL_BACKOFF_EN
            BLOCKED: nxt = BACKOFF;
            BACKOFF: if (phase == BACKOFF_LAST) nxt = SPIN;
            SPIN:    if (phase == SPIN_LAST) nxt = CRUISE;
`else
            BLOCKED: nxt = STOP;
`endif
            STOP:    if (!l_obs && !r_obs) nxt = CRUISE;
            default: nxt = CRUISE;
        endcase
    end

    // DIR is built from the next state so it moves on the same edge as state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= CRUISE;
            bus.DIR     <= 4'b0000;
            bus.blocked <= 1'b0;
        end else begin
            cur         <= nxt;
            bus.DIR     <= dir_code(nxt, bus.direction);
            bus.blocked <= (nxt == BLOCKED) && (cur != BLOCKED);
        end
    end

    assign bus.state = cur;

endmodule

// File: tb/tb_direction_control_multi.sv
// Directed bench for direction_control_multi with N_SENSORS=2, DEBOUNCE=4, BACKOFF=8, SPIN=6.
module tb_direction_control_multi;
    logic clk;
    logic rst;

    direction_control_multi_if #(.N_SENSORS(2)) bus ();

    direction_control_multi #(
        .N_SENSORS       (2),
        .DEBOUNCE_CYCLES (4),
        .BACKOFF_CYCLES  (8),
        .SPIN_CYCLES     (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] ls;
        logic [1:0] rs;
        logic       dir_in;
        logic [3:0] dir;
        logic [2:0] st;
    } vec_t;

    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] d, input logic [2:0] s, input logic b);
        n_checks++;
        if (bus.DIR !== d || bus.state !== s || bus.blocked !== b) begin
            n_fail++;
            $display("FAIL %s: got DIR=%b state=%0d blocked=%b, want DIR=%b state=%0d blocked=%b",
                     name, bus.DIR, bus.state, bus.blocked, d, s, b);
        end
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_async"}, 4'b0000, 3'd0, 1'b0);
        step();
        check({tag, "_held"}, 4'b0000, 3'd0, 1'b0);
        rst = 1'b1;
        step();
        check({tag, "_release"}, 4'b1010, 3'd0, 1'b0);
        repeat (8) step();
        check({tag, "_settled"}, 4'b1010, 3'd0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{2'b00, 2'b00, 1'b0, 4'b1010, 3'd0};
        tbl[1] = '{2'b01, 2'b00, 1'b0, 4'b1000, 3'd2};
        tbl[2] = '{2'b00, 2'b01, 1'b0, 4'b0010, 3'd1};
        tbl[3] = '{2'b00, 2'b01, 1'b1, 4'b0001, 3'd1};
        tbl[4] = '{2'b10, 2'b00, 1'b1, 4'b0100, 3'd2};
        tbl[5] = '{2'b00, 2'b00, 1'b1, 4'b0101, 3'd0};
        tbl[6] = '{2'b00, 2'b10, 1'b0, 4'b0010, 3'd1};
        tbl[7] = '{2'b11, 2'b00, 1'b0, 4'b1000, 3'd2};
        tbl[8] = '{2'b00, 2'b00, 1'b0, 4'b1010, 3'd0};

        rst           = 1'b0;
        bus.ls        = 2'b00;
        bus.rs        = 2'b00;
        bus.direction = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 4'b0000, 3'd0, 1'b0);
        rst = 1'b1;
        #2;
        check("released_before_edge", 4'b0000, 3'd0, 1'b0);
        step();
        check("first_edge_cruise", 4'b1010, 3'd0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            bus.ls        = tbl[i].ls;
            bus.rs        = tbl[i].rs;
            bus.direction = tbl[i].dir_in;
            repeat (10) step();
            check($sformatf("vec%0d", i), tbl[i].dir, tbl[i].st, 1'b0);
        end

        // Held change shows up exactly seven edges after it is first sampled.
        bus.ls = 2'b01;
        repeat (6) step();
        check("latency_edge6", 4'b1010, 3'd0, 1'b0);
        step();
        check("latency_edge7", 4'b1000, 3'd2, 1'b0);
        bus.ls = 2'b00;
        repeat (10) step();
        check("latency_clear", 4'b1010, 3'd0, 1'b0);

        bus.ls = 2'b01;
        repeat (3) step();
        bus.ls = 2'b00;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("glitch_c%0d", k), 4'b1010, 3'd0, 1'b0);
        end

        bus.direction = 1'b1;
        step();
        check("dir_toggle_next_edge", 4'b0101, 3'd0, 1'b0);
        bus.rs = 2'b01;
        repeat (7) step();
        check("rev_turn_l", 4'b0001, 3'd1, 1'b0);
        bus.rs        = 2'b00;
        bus.direction = 1'b0;
        repeat (10) step();
        check("rev_restore", 4'b1010, 3'd0, 1'b0);

        // Both sides blocked: filters flip on edge 6, BLOCKED on edge 7.
        bus.ls = 2'b10;
        bus.rs = 2'b01;
        repeat (6) step();
        check("blk_pre", 4'b1010, 3'd0, 1'b0);
        step();
        check("blk_entry", 4'b0000, 3'd3, 1'b1);
`ifdef DIRCTL_BACKOFF_EN
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("backoff_c%0d", k), 4'b0101, 3'd4, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("spin_c%0d", k), 4'b1001, 3'd5, 1'b0);
        end
        step();
        check("reeval_cruise", 4'b1010, 3'd0, 1'b0);
        step();
        check("reeval_blocked", 4'b0000, 3'd3, 1'b1);
        bus.ls = 2'b00;
        bus.rs = 2'b00;
        repeat (3) step();
        check("backoff_c3", 4'b0101, 3'd4, 1'b0);
        reset_pulse("rst_backoff");
`else
        step();
        check("stop_entry", 4'b0000, 3'd6, 1'b0);
        repeat (4) step();
        check("stop_hold", 4'b0000, 3'd6, 1'b0);
        bus.ls = 2'b00;
        repeat (8) step();
        check("stop_right_only", 4'b0000, 3'd6, 1'b0);
        bus.rs = 2'b00;
        repeat (6) step();
        check("stop_last", 4'b0000, 3'd6, 1'b0);
        step();
        check("stop_exit", 4'b1010, 3'd0, 1'b0);
        bus.ls = 2'b10;
        bus.rs = 2'b01;
        repeat (8) step();
        check("stop_again", 4'b0000, 3'd6, 1'b0);
        bus.ls = 2'b00;
        bus.rs = 2'b00;
        reset_pulse("rst_stop");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
